// File: rtl/hazard_flush_ctrl.sv
// hazard_flush_ctrl: hazard and flush controller for the 5-stage MIPS pipeline.
//
// Generates the PC and IF/ID enables, the IF/ID and ID/EX flushes and a freeze of the later
// pipeline registers from three conditions:
//   - a load in EX whose destination is read by the instruction in ID (load-use),
//   - a taken branch or jump resolved in EX (redirect),
//   - a data memory that is not ready (MemBusy).
// A redirect is followed by REDIRECT_FLUSH_CYCLES cycles of IF/ID flush (the shadow). A redirect
// that arrives while memory is busy is remembered and applied on the first non-busy cycle.
//
// Parameters:
//   REDIRECT_FLUSH_CYCLES  extra IF/ID flush cycles after a redirect (0..7)
//   STAT_W                 width of the statistics counters
//
// Ports:
//   Clk, Rst               clock; asynchronous active-low reset
//   ID_EX_MemRead/RegisterRt   load in EX and its destination register
//   IF_ID_RegisterRs/Rt/UsesRt source registers of the instruction in ID
//   RedirectEX, MemBusy    redirect resolved in EX; data memory wait
//   PCWrite, IF_ID_Write   front-end enables
//   IF_ID_Flush, ID_EX_Flush   register flushes
//   PipeHold               freezes ID/EX, EX/MEM and MEM/WB
//   StallCount, FlushCount saturating stall-cycle and redirect counters
//
// Optional feature: define HAZARD_STATS_EN to build the StallCount/FlushCount ports and
// counters. Without it the ports are absent and the control behaviour is unchanged.

module hazard_flush_ctrl #(
  parameter int unsigned REDIRECT_FLUSH_CYCLES = 1,
  parameter int unsigned STAT_W                = 16
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       ID_EX_MemRead,
  input  logic [4:0] ID_EX_RegisterRt,
  input  logic [4:0] IF_ID_RegisterRs,
  input  logic [4:0] IF_ID_RegisterRt,
  input  logic       IF_ID_UsesRt,
  input  logic       RedirectEX,
  input  logic       MemBusy,
  output logic       PCWrite,
  output logic       IF_ID_Write,
  output logic       IF_ID_Flush,
  output logic       ID_EX_Flush,
  output logic       PipeHold
`ifdef HAZARD_STATS_EN
  ,
  output logic [STAT_W-1:0] StallCount,
  output logic [STAT_W-1:0] FlushCount
`endif
);

  typedef enum logic [1:0] {StRun, StHold, StShadow} state_e;

  localparam logic [2:0] ShadowLen = 3'(REDIRECT_FLUSH_CYCLES);

  state_e     st_q, st_d;
  logic [2:0] cnt_q, cnt_d;
  logic       pend_q, pend_d;
  logic       load_use;
  logic       redirect_now;

  // Register 0 is hard-wired to zero, so a load targeting it never creates a dependency.
  assign load_use = ID_EX_MemRead && (ID_EX_RegisterRt != 5'd0) &&
                    ((ID_EX_RegisterRt == IF_ID_RegisterRs) ||
                     (IF_ID_UsesRt && (ID_EX_RegisterRt == IF_ID_RegisterRt)));

  assign redirect_now = !MemBusy && (RedirectEX || pend_q);

  always_comb begin
    st_d        = st_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    PCWrite     = 1'b1;
    IF_ID_Write = 1'b1;
    IF_ID_Flush = 1'b0;
    ID_EX_Flush = 1'b0;
    PipeHold    = 1'b0;

    if (MemBusy) begin
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
      PipeHold    = 1'b1;
      st_d        = StHold;
      pend_d      = pend_q | RedirectEX;
    end else if (redirect_now) begin
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
      pend_d      = 1'b0;
      if (ShadowLen != 3'd0) begin
        st_d  = StShadow;
        cnt_d = ShadowLen;
      end else begin
        st_d = StRun;
      end
    end else if (st_q == StShadow) begin
      // Wrong-path fetches are still arriving; load-use is irrelevant for them.
      IF_ID_Flush = 1'b1;
      cnt_d       = cnt_q - 3'd1;
      if (cnt_q == 3'd1) begin
        st_d = StRun;
      end
    end else if (load_use) begin
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Flush = 1'b1;
      st_d        = StRun;
    end else begin
      st_d = StRun;
    end

    // Keep the pipe empty and the front end stopped while reset is asserted.
    if (!Rst) begin
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
      PipeHold    = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      st_q   <= StRun;
      cnt_q  <= 3'd0;
      pend_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] stall_cnt_q;
  logic [STAT_W-1:0] flush_cnt_q;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!PCWrite && (stall_cnt_q != {STAT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (redirect_now && (flush_cnt_q != {STAT_W{1'b1}})) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;
`else
  // Keeps the counter width parameter referenced when the counters are compiled out.
  logic unused_stat_w;
  assign unused_stat_w = (STAT_W == 0);
`endif

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Scoreboard bench for hazard_flush_ctrl: a driver applies directed and random stimulus and
// pushes the reference model's expected outputs; a monitor pops and compares on the falling edge.
module tb_hazard_flush_ctrl;

  localparam int unsigned Shadow = 1;
  localparam int unsigned StatW  = 3;
  localparam int unsigned StatMax = (1 << StatW) - 1;

  logic       Clk;
  logic       Rst;
  logic       ID_EX_MemRead;
  logic [4:0] ID_EX_RegisterRt;
  logic [4:0] IF_ID_RegisterRs;
  logic [4:0] IF_ID_RegisterRt;
  logic       IF_ID_UsesRt;
  logic       RedirectEX;
  logic       MemBusy;
  logic       PCWrite;
  logic       IF_ID_Write;
  logic       IF_ID_Flush;
  logic       ID_EX_Flush;
  logic       PipeHold;
`ifdef HAZARD_STATS_EN
  logic [StatW-1:0] StallCount;
  logic [StatW-1:0] FlushCount;
`endif

  hazard_flush_ctrl #(
    .REDIRECT_FLUSH_CYCLES(Shadow),
    .STAT_W               (StatW)
  ) dut (
    .Clk             (Clk),
    .Rst             (Rst),
    .ID_EX_MemRead   (ID_EX_MemRead),
    .ID_EX_RegisterRt(ID_EX_RegisterRt),
    .IF_ID_RegisterRs(IF_ID_RegisterRs),
    .IF_ID_RegisterRt(IF_ID_RegisterRt),
    .IF_ID_UsesRt    (IF_ID_UsesRt),
    .RedirectEX      (RedirectEX),
    .MemBusy         (MemBusy),
    .PCWrite         (PCWrite),
    .IF_ID_Write     (IF_ID_Write),
    .IF_ID_Flush     (IF_ID_Flush),
    .ID_EX_Flush     (ID_EX_Flush),
    .PipeHold        (PipeHold)
`ifdef HAZARD_STATS_EN
    ,
    .StallCount      (StallCount),
    .FlushCount      (FlushCount)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Outputs packed as {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, PipeHold}.
  typedef struct packed {
    logic [4:0]  outs;
    logic [31:0] sc;
    logic [31:0] fc;
    logic [31:0] cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  // Reference model state: remaining shadow cycles, a deferred redirect, statistics.
  int unsigned shadow_left = 0;
  bit          pending     = 0;
  int unsigned m_stalls    = 0;
  int unsigned m_flushes   = 0;

  task automatic drive(input bit rst, input bit mr, input int ert, input int rs, input int rt,
                       input bit urt, input bit redir, input bit busy);
    exp_t e;
    bit   lu;
    bit   p2;
    @(posedge Clk);
    #1;
    Rst              = rst;
    ID_EX_MemRead    = mr;
    ID_EX_RegisterRt = 5'(ert);
    IF_ID_RegisterRs = 5'(rs);
    IF_ID_RegisterRt = 5'(rt);
    IF_ID_UsesRt     = urt;
    RedirectEX       = redir;
    MemBusy          = busy;
    lu = mr && (ert != 0) && ((ert == rs) || (urt && (ert == rt)));
    p2 = 0;
    e.cyc = cyc;
    if (!rst) begin
      shadow_left = 0;
      pending     = 0;
      m_stalls    = 0;
      m_flushes   = 0;
      e.outs      = 5'b00110;
    end else if (busy) begin
      e.outs      = 5'b00001;
      pending     = pending || redir;
      shadow_left = 0;
    end else if (redir || pending) begin
      e.outs      = 5'b11110;
      pending     = 0;
      shadow_left = Shadow;
      p2          = 1;
    end else if (shadow_left > 0) begin
      e.outs      = 5'b11100;
      shadow_left = shadow_left - 1;
    end else if (lu) begin
      e.outs = 5'b00010;
    end else begin
      e.outs = 5'b11000;
    end
    e.sc = m_stalls;
    e.fc = m_flushes;
    if (rst) begin
      if (!e.outs[4] && m_stalls < StatMax) m_stalls++;
      if (p2 && m_flushes < StatMax) m_flushes++;
    end
    exp_q.push_back(e);
    cyc++;
  endtask

  task automatic idle();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: one comparison set per expected entry, sampled mid-cycle.
  initial begin
    exp_t e;
    logic [4:0] got;
    forever begin
      @(negedge Clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, PipeHold};
        n_cmp++;
        if (got !== e.outs) begin
          n_err++;
          $display("FAIL outs cyc=%0d got=%b want=%b (PCWr,IFIDWr,IFIDFl,IDEXFl,Hold)",
                   e.cyc, got, e.outs);
        end
`ifdef HAZARD_STATS_EN
        n_cmp++;
        if ({29'd0, StallCount} !== e.sc || {29'd0, FlushCount} !== e.fc) begin
          n_err++;
          $display("FAIL stats cyc=%0d got=%0d/%0d want=%0d/%0d", e.cyc, StallCount,
                   FlushCount, e.sc, e.fc);
        end
`endif
      end
    end
  end

  initial begin
    int wait_cnt;
    Rst = 1'b0;
    ID_EX_MemRead = 0; ID_EX_RegisterRt = 0; IF_ID_RegisterRs = 0; IF_ID_RegisterRt = 0;
    IF_ID_UsesRt = 0; RedirectEX = 0; MemBusy = 0;

    drive(0, 0, 0, 0, 0, 0, 0, 0);            // reset outputs
    idle();
    // Load-use on rs, and register 0 exemption.
    drive(1, 1, 5, 5, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    // rt dependency only counts when rt is a source.
    drive(1, 1, 7, 3, 7, 0, 0, 0);
    drive(1, 1, 7, 3, 7, 1, 0, 0);
    // Redirect pulse, shadow masks load-use, then back in RUN.
    drive(1, 0, 0, 0, 0, 0, 1, 0);
    drive(1, 1, 5, 5, 0, 0, 0, 0);
    drive(1, 1, 5, 5, 0, 0, 0, 0);
    // Redirect deferred across a 3-cycle memory wait.
    drive(1, 0, 0, 0, 0, 0, 1, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    idle();
    idle();
    idle();
    // Asynchronous reset in the shadow, then clean pass-through.
    drive(1, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    idle();
    // Stall counter saturation run.
    for (int i = 0; i < 10; i++) drive(1, 1, 9, 9, 0, 0, 0, 0);
    idle();

    // Random traffic on a small register set so hazards are frequent.
    for (int i = 0; i < 800; i++) begin
      drive(($urandom_range(0, 79) != 0), $urandom_range(0, 1), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
            ($urandom_range(0, 6) == 0), ($urandom_range(0, 4) == 0));
    end
    idle();

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 20) begin
      @(posedge Clk);
      wait_cnt++;
    end
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain got=%0d pending entries want=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
